// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_pkg
// Description : Writeback select encoding and constants shared by the
//               writeback stage and the write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_arbiter_pkg;

  // Writeback source select; encoding 3 is unused and treated as illegal.
  typedef enum logic [1:0] {
    WB_ALU      = 2'd0,
    WB_DATA_MEM = 2'd1,
    WB_PC       = 2'd2
  } wb_sel_t;

  localparam int PC_INCR    = 4;
  localparam int REG_ADDR_W = 5;

  // Only ALU and PC results may travel down the execute path.
  function automatic logic ex_sel_legal(input logic [1:0] sel);
    return (sel == WB_ALU) || (sel == WB_PC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter_if
// Description : Execute, load-return and register-file write bundle for the
//               writeback arbiter. master = pipeline side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  ex_valid;
  logic                  ex_ready;
  logic [1:0]            ex_sel;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       ex_alu_data;
  logic [XLEN-1:0]       ex_pc;

  logic                  ld_valid;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic [CNT_W-1:0]      buf_count;
  logic                  sel_err;

  modport master (
    output ex_valid, ex_sel, ex_rd, ex_alu_data, ex_pc,
    output ld_valid, ld_rd, ld_data,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, buf_count, sel_err
  );

  modport slave (
    input  ex_valid, ex_sel, ex_rd, ex_alu_data, ex_pc,
    input  ld_valid, ld_rd, ld_data,
    output ex_ready, rf_we, rf_waddr, rf_wdata, buf_count, sel_err
  );

endinterface
`default_nettype wire

// File: rtl/writeback_arbiter_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_fifo
// Description : In-order circular skid buffer of {valid, rd, data} for
//               execute results waiting on the register-file write port.
//               A kill strobe clears the valid bit of every entry whose rd
//               matches; killed entries keep their slot and pop silently.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_skid_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  wire logic                             clk,
  input  wire logic                             rst_n,
  input  wire logic                             push_i,
  input  wire logic                             push_valid_i,
  input  wire logic [REG_ADDR_W-1:0]            push_rd_i,
  input  wire logic [XLEN-1:0]                  push_data_i,
  input  wire logic                             pop_i,
  input  wire logic                             kill_i,
  input  wire logic [REG_ADDR_W-1:0]            kill_rd_i,
  output logic                                  head_valid_o,
  output logic [REG_ADDR_W-1:0]                 head_rd_o,
  output logic [XLEN-1:0]                       head_data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]        count_o,
  output logic                                  empty_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  logic                  valid_q [BUF_DEPTH];
  logic [REG_ADDR_W-1:0] rd_q    [BUF_DEPTH];
  logic [XLEN-1:0]       data_q  [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; push and pop together leave count as is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= ptr_next(tail_q);
      if (pop_i)  head_q <= ptr_next(head_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage: a push into a slot takes precedence over a kill of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (push_i && (tail_q == PTR_W'(i))) begin
          valid_q[i] <= push_valid_i;
          rd_q[i]    <= push_rd_i;
          data_q[i]  <= push_data_i;
        end else if (kill_i && (rd_q[i] == kill_rd_i)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign head_valid_o = valid_q[head_q];
  assign head_rd_o    = rd_q[head_q];
  assign head_data_o  = data_q[head_q];
  assign count_o      = count_q;
  assign empty_o      = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Sequencer for the single register-file write port. Load
//               returns always win; execute results bypass straight to the
//               port when it is free, otherwise wait in an in-order skid
//               buffer. Applies the writeback select, filters x0 writes and
//               back-pressures execute when the buffer is full.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  ex_accept;
  logic                  ex_legal;
  logic [XLEN-1:0]       ex_payload;

  logic                  fifo_push_d;
  logic                  fifo_push_valid_d;
  logic                  fifo_pop_d;
  logic                  fifo_kill_d;
  logic                  head_valid;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;

  logic                  rf_we_d,    rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0]       rf_wdata_d, rf_wdata_q;
  logic                  sel_err_d,  sel_err_q;

  // Ready depends on registered occupancy only, never on this cycle's load.
  assign bus.ex_ready = (fifo_count < CNT_W'(BUF_DEPTH)) && rst_n;
  assign ex_accept    = bus.ex_valid && bus.ex_ready;
  assign ex_legal     = ex_sel_legal(bus.ex_sel);
  assign ex_payload   = (bus.ex_sel == WB_PC) ? (bus.ex_pc + XLEN'(PC_INCR))
                                              : bus.ex_alu_data;

  wb_skid_fifo #(
    .XLEN      (XLEN),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_skid_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push_d),
    .push_valid_i (fifo_push_valid_d),
    .push_rd_i    (bus.ex_rd),
    .push_data_i  (ex_payload),
    .pop_i        (fifo_pop_d),
    .kill_i       (fifo_kill_d),
    .kill_rd_i    (bus.ld_rd),
    .head_valid_o (head_valid),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty)
  );

  // Port arbitration: load, then buffer head, then a bypassing execute result.
  // Dropped (illegal or misrouted) execute results are accepted but never stored.
  always_comb begin
    fifo_push_d       = 1'b0;
    fifo_push_valid_d = 1'b1;
    fifo_pop_d        = 1'b0;
    fifo_kill_d       = 1'b0;
    rf_we_d           = 1'b0;
    rf_waddr_d        = rf_waddr_q;
    rf_wdata_d        = rf_wdata_q;
    sel_err_d         = ex_accept && !ex_legal;

    if (bus.ld_valid) begin
      // Load is younger than everything buffered: same-rd entries are stale.
      fifo_kill_d       = 1'b1;
      fifo_push_d       = ex_accept && ex_legal;
      fifo_push_valid_d = (bus.ex_rd != bus.ld_rd);
      rf_we_d           = (bus.ld_rd != '0);
      rf_waddr_d        = bus.ld_rd;
      rf_wdata_d        = bus.ld_data;
    end else if (!fifo_empty) begin
      fifo_pop_d  = 1'b1;
      fifo_push_d = ex_accept && ex_legal;
      rf_we_d     = head_valid && (head_rd != '0);
      rf_waddr_d  = head_rd;
      rf_wdata_d  = head_data;
    end else if (ex_accept && ex_legal) begin
      rf_we_d    = (bus.ex_rd != '0);
      rf_waddr_d = bus.ex_rd;
      rf_wdata_d = ex_payload;
    end
  end

  // Output register for the write port and the select-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.buf_count = fifo_count;
  assign bus.sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Directed self-checking bench for writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  writeback_arbiter_if #(.XLEN(32), .BUF_DEPTH(2)) bus ();

  writeback_arbiter #(.XLEN(32), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.ex_valid    = 1'b0;
    bus.ex_sel      = 2'd0;
    bus.ex_rd       = '0;
    bus.ex_alu_data = '0;
    bus.ex_pc       = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_rd       = '0;
    bus.ld_data     = '0;
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    bus.ex_valid    = 1'b1;
    bus.ex_sel      = 2'd0;
    bus.ex_rd       = 5'd5;
    bus.ex_alu_data = 32'h1234_5678;
    repeat (3) step();
    total++; if (bus.ex_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ex_ready); end
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.rf_we); end
    total++; if (bus.rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d want=0", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", bus.rf_wdata); end
    total++; if (bus.buf_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.buf_count); end
    total++; if (bus.sel_err !== 1'b0) begin bad++; $display("FAIL reset_selerr got=%b want=0", bus.sel_err); end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.ex_ready); end
    step();
    total++; if (bus.buf_count !== 2'd0) begin bad++; $display("FAIL release_count got=%0d want=0", bus.buf_count); end
  endtask

  task automatic test_bypass;
    bus.ex_valid    = 1'b1;
    bus.ex_sel      = 2'(WB_ALU);
    bus.ex_rd       = 5'd5;
    bus.ex_alu_data = 32'hDEAD_BEEF;
    total++; if (bus.ex_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b want=1", bus.ex_ready); end
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL bypass_alu got we=%b a=%0d d=%h want we=1 a=5 d=deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    total++; if (bus.buf_count !== 2'd0) begin bad++; $display("FAIL bypass_count got=%0d want=0", bus.buf_count); end
    bus.ex_sel      = 2'(WB_PC);
    bus.ex_rd       = 5'd6;
    bus.ex_alu_data = 32'h5555_5555;
    bus.ex_pc       = 32'hFFFF_FFFC;
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd6 || bus.rf_wdata !== 32'h0) begin
      bad++; $display("FAIL bypass_pc_wrap got we=%b a=%0d d=%h want we=1 a=6 d=00000000", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    bus.ex_pc = 32'h0000_1000;
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'h0000_1004) begin
      bad++; $display("FAIL bypass_pc got we=%b d=%h want we=1 d=00001004", bus.rf_we, bus.rf_wdata);
    end
    idle_inputs();
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL bypass_idle got=%b want=0", bus.rf_we); end
  endtask

  task automatic test_contention;
    logic [4:0]  ex_rds    [3] = '{5'd10, 5'd11, 5'd12};
    logic        exp_ready [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp_we    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  exp_addr  [7] = '{5'd1, 5'd2, 5'd3, 5'd10, 5'd11, 5'd12, 5'd0};
    logic [31:0] exp_data  [7] = '{32'hA1, 32'hA2, 32'hA3, 32'h100A, 32'h100B, 32'h100C, 32'h0};
    int          exp_cnt   [7] = '{1, 2, 2, 1, 1, 0, 0};
    int          idx = 0;
    logic        acc;
    for (int c = 0; c < 7; c++) begin
      bus.ld_valid    = (c < 3);
      bus.ld_rd       = 5'(c + 1);
      bus.ld_data     = 32'hA0 + 32'(c + 1);
      bus.ex_valid    = (idx < 3);
      bus.ex_sel      = 2'(WB_ALU);
      bus.ex_rd       = (idx < 3) ? ex_rds[idx] : 5'd0;
      bus.ex_alu_data = 32'h1000 + 32'(bus.ex_rd);
      total++; if (bus.ex_ready !== exp_ready[c]) begin
        bad++; $display("FAIL cont_ready c=%0d got=%b want=%b", c, bus.ex_ready, exp_ready[c]);
      end
      acc = bus.ex_valid && bus.ex_ready;
      step();
      if (acc) idx++;
      total++; if (bus.rf_we !== exp_we[c]) begin
        bad++; $display("FAIL cont_we c=%0d got=%b want=%b", c, bus.rf_we, exp_we[c]);
      end
      if (exp_we[c]) begin
        total++; if (bus.rf_waddr !== exp_addr[c] || bus.rf_wdata !== exp_data[c]) begin
          bad++; $display("FAIL cont_write c=%0d got a=%0d d=%h want a=%0d d=%h", c, bus.rf_waddr, bus.rf_wdata, exp_addr[c], exp_data[c]);
        end
      end
      total++; if (int'(bus.buf_count) != exp_cnt[c]) begin
        bad++; $display("FAIL cont_count c=%0d got=%0d want=%0d", c, bus.buf_count, exp_cnt[c]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_squash;
    // Load to x0 forces rd=7 into the buffer without producing a write.
    bus.ld_valid    = 1'b1;
    bus.ld_rd       = 5'd0;
    bus.ld_data     = 32'h55;
    bus.ex_valid    = 1'b1;
    bus.ex_sel      = 2'(WB_ALU);
    bus.ex_rd       = 5'd7;
    bus.ex_alu_data = 32'h11;
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL x0_load got=%b want=0", bus.rf_we); end
    total++; if (bus.buf_count !== 2'd1) begin bad++; $display("FAIL squash_fill got=%0d want=1", bus.buf_count); end
    bus.ex_valid = 1'b0;
    bus.ld_rd    = 5'd7;
    bus.ld_data  = 32'h22;
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h22) begin
      bad++; $display("FAIL squash_load got we=%b a=%0d d=%h want we=1 a=7 d=22", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    idle_inputs();
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL squash_silent got=%b want=0", bus.rf_we); end
    total++; if (bus.buf_count !== 2'd0) begin bad++; $display("FAIL squash_count got=%0d want=0", bus.buf_count); end
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL squash_after got=%b want=0", bus.rf_we); end
  endtask

  task automatic test_illegal_x0;
    logic [1:0] bad_sel [2] = '{2'd3, 2'(WB_DATA_MEM)};
    for (int k = 0; k < 2; k++) begin
      bus.ex_valid    = 1'b1;
      bus.ex_sel      = bad_sel[k];
      bus.ex_rd       = 5'd9;
      bus.ex_alu_data = 32'h99;
      step();
      total++; if (bus.rf_we !== 1'b0 || bus.sel_err !== 1'b1) begin
        bad++; $display("FAIL illegal_sel k=%0d got we=%b err=%b want we=0 err=1", k, bus.rf_we, bus.sel_err);
      end
      total++; if (bus.buf_count !== 2'd0) begin bad++; $display("FAIL illegal_count k=%0d got=%0d want=0", k, bus.buf_count); end
      idle_inputs();
      step();
      total++; if (bus.sel_err !== 1'b0 || bus.rf_we !== 1'b0) begin
        bad++; $display("FAIL illegal_pulse k=%0d got we=%b err=%b want 0 0", k, bus.rf_we, bus.sel_err);
      end
    end
    bus.ld_valid = 1'b1;
    bus.ld_rd    = 5'd0;
    bus.ld_data  = 32'h77;
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL x0_ld got=%b want=0", bus.rf_we); end
    bus.ld_valid    = 1'b0;
    bus.ex_valid    = 1'b1;
    bus.ex_sel      = 2'(WB_ALU);
    bus.ex_rd       = 5'd0;
    bus.ex_alu_data = 32'h88;
    step();
    total++; if (bus.rf_we !== 1'b0 || bus.sel_err !== 1'b0) begin
      bad++; $display("FAIL x0_ex got we=%b err=%b want 0 0", bus.rf_we, bus.sel_err);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_burst;
    for (int c = 0; c < 2; c++) begin
      bus.ld_valid    = 1'b1;
      bus.ld_rd       = 5'(c + 1);
      bus.ld_data     = 32'hB0 + 32'(c);
      bus.ex_valid    = 1'b1;
      bus.ex_sel      = 2'(WB_ALU);
      bus.ex_rd       = 5'(20 + c);
      bus.ex_alu_data = 32'hC0 + 32'(c);
      step();
    end
    total++; if (bus.buf_count !== 2'd2) begin bad++; $display("FAIL midrst_fill got=%0d want=2", bus.buf_count); end
    idle_inputs();
    rst_n = 1'b0;
    step();
    total++; if (bus.rf_we !== 1'b0 || bus.buf_count !== 2'd0 || bus.ex_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_state got we=%b cnt=%0d rdy=%b want 0 0 0", bus.rf_we, bus.buf_count, bus.ex_ready);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (bus.rf_we !== 1'b0 || bus.buf_count !== 2'd0) begin
        bad++; $display("FAIL midrst_stale c=%0d got we=%b cnt=%0d want 0 0", c, bus.rf_we, bus.buf_count);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_contention();
    test_squash();
    test_illegal_x0();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Sequencer for the single register-file write port at the end of the pipeline. Two sources compete for the port: execute-side results (ALU output or link address PC+4) and data-memory load returns, which arrive with variable latency. Loads always win the port. Execute results that cannot be written immediately wait in a small in-order skid buffer. The arbiter applies the writeback-select mux, suppresses writes to x0, and back-pressures execute when the buffer is full.

## Interface
- XLEN, 32, datapath width
- BUF_DEPTH, 2, execute-result skid buffer entries (>=1)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  execute result offered
- ex_ready  out  1  execute result accepted this cycle when ex_valid && ex_ready
- ex_sel  in  2  writeback select: ALU=0, DATA_MEM=1, PC=2, 3 illegal
- ex_rd  in  5  destination register
- ex_alu_data  in  XLEN  ALU result
- ex_pc  in  XLEN  PC of the instruction
- ld_valid  in  1  load return (never stalled)
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data from data memory
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- buf_count  out  $clog2(BUF_DEPTH+1)  occupied buffer entries
- sel_err  out  1  one-cycle pulse on illegal or misrouted ex_sel

## Operation
- Execute payload resolution at acceptance: ALU -> ex_alu_data; PC -> ex_pc + 4, modulo 2^XLEN; DATA_MEM on the execute path is misrouted.
  - The DATA_MEM encoding on the execute path is dropped, and sel_err pulses.
  - ex_sel=3 is dropped, and sel_err pulses.
  - A dropped entry is still accepted (handshake completes) but never written.
- Port priority each cycle: ld_valid, then buffer head, then a newly accepted execute result.
- Bypass: buffer empty and ld_valid=0 -> an accepted execute result goes straight to the output register and is not buffered.
- Otherwise an accepted execute result is pushed to the buffer tail. The buffer is strictly FIFO.
- ex_ready = (buf_count < BUF_DEPTH) && rst_n. It depends on registered state only, so it does not fall through from ld_valid.
- Simultaneous pop (head wins port) and push in the same cycle: legal, and the count is unchanged.
- Squash rule: loads are younger than every buffered execute entry (pipeline property).
  - A granted load invalidates all buffered entries with the same rd.
  - A simultaneously accepted execute result with the same rd is also invalidated.
  - Invalidated entries still occupy a slot but pop without writing.
- x0: any winning source with rd=0 produces rf_we=0. The slot is still consumed.
- Reset mid-operation: buffer contents are discarded, count returns to 0, and no write issues in the cycle after reset.

## Timing
- All outputs except ex_ready are registered.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, buf_count=0, sel_err=0; ex_ready=0 while rst_n=0.
- Load latency: ld_valid in cycle N -> rf_we in cycle N+1.
- Execute latency with no contention: accepted in cycle N -> write in cycle N+1.
- Each cycle of load traffic while the buffer is occupied delays the buffer head by one cycle.
- Load starvation of execute is permitted. Execute is back-pressured by ex_ready only.
- sel_err is asserted in cycle N+1 for an offending acceptance in cycle N.

## Structure
- Shared package (also used by the writeback stage):
  - wb_sel_t enum: WB_ALU=0, WB_DATA_MEM=1, WB_PC=2
  - PC_INCR=4
  - REG_ADDR_W=5
- Sub-module wb_skid_fifo: parameterised BUF_DEPTH circular buffer of {valid, rd, data}.
  - Push and pop ports.
  - Per-entry rd-match kill port.
  - Count output.
- Arbitration, select mux, x0 filter and output register stay in writeback_arbiter.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles with ex_valid=1.
  - ex_ready=0 and all outputs 0.
  - After release, ex_ready=1 and buf_count=0.
- Execute bypass cycles:
  - ex_sel=ALU, rd=5, data=0xDEADBEEF at cycle N -> rf_we=1, waddr=5, wdata=0xDEADBEEF at N+1.
  - ex_sel=PC, ex_pc=0xFFFFFFFC -> wdata=0x00000000 (wrap).
- Contention: ld_valid for 3 consecutive cycles (rd=1,2,3) while execute offers rd=10,11,12 every cycle.
  - Loads are written at N+1..N+3.
  - ex_ready drops after 2 buffered entries.
  - Then rd=10,11,12 are written in order with no loss.
- Squash: buffer holds rd=7 (0x11); a load returns to rd=7 (0x22).
  - Only the write 7<-0x22 occurs.
  - The squashed slot pops silently and buf_count returns to 0.
- Illegal select and x0:
  - ex_sel=3 -> no write and sel_err pulse at N+1.
  - ex_sel=DATA_MEM -> no write and sel_err pulse.
  - Load to rd=0 -> rf_we stays 0.
- Reset mid-burst: assert rst_n=0 with buf_count=2.
  - The next cycle shows rf_we=0 and buf_count=0.
  - No stale entry is written after release.
